// File: rtl/elastic_pipe_register_2d.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_pipe_register_2d
//  Description : Multi-stage, multi-lane elastic pipeline register with a
//                valid/ready handshake, per-lane mask, bubble collapsing,
//                synchronous flush and an occupancy count. The optional skid
//                register ahead of stage 0 is enabled by defining the macro
//                ELASTIC_PIPE_SKID_EN. With the skid, in_ready has no
//                combinational path from out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe_register_2d #(
    parameter int DATAW       = 4,
    parameter int ARRAY_DEPTH = 4,
    parameter int NUM_STAGES  = 2,
    parameter int CNTW        = $clog2(NUM_STAGES + 2)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAW-1:0]       in_data [ARRAY_DEPTH-1:0],
    input  logic [ARRAY_DEPTH-1:0] in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATAW-1:0]       out_data [ARRAY_DEPTH-1:0],
    output logic [ARRAY_DEPTH-1:0] out_mask,
    output logic [CNTW-1:0]        occupancy
);

    localparam int LAST = NUM_STAGES - 1;

    // Per-stage state
    logic [NUM_STAGES-1:0]  v;
    logic [ARRAY_DEPTH-1:0] mask_q [NUM_STAGES-1:0];
    logic [DATAW-1:0]       data_q [NUM_STAGES-1:0][ARRAY_DEPTH-1:0];
    logic [CNTW-1:0]        occ_q;

    // Handshake / movement terms
    logic [NUM_STAGES-1:0]  adv;
    logic [NUM_STAGES-1:0]  load_ok;
    logic                   accept;
    logic                   out_fire;

    // Word presented to stage 0 (from the input, or from the skid if present)
    logic                   stage0_load;
    logic [ARRAY_DEPTH-1:0] src_mask;
    logic [DATAW-1:0]       src_data [ARRAY_DEPTH-1:0];
    logic [DATAW-1:0]       in_masked [ARRAY_DEPTH-1:0];

    // Masked-off lanes are stored as zero so the downstream never sees stale lane data
    always_comb begin
        for (int l = 0; l < ARRAY_DEPTH; l++) begin
            in_masked[l] = in_mask[l] ? in_data[l] : '0;
        end
    end

    // Advance chain from the output backwards: a stage moves when the next one frees up
    always_comb begin
        adv       = '0;
        adv[LAST] = v[LAST] && out_ready;
        for (int s = LAST - 1; s >= 0; s--) begin
            adv[s] = v[s] && (!v[s+1] || adv[s+1]);
        end
    end

    assign load_ok  = ~v | adv;
    assign out_fire = v[LAST] && out_ready;

`ifdef ELASTIC_PIPE_SKID_EN
    logic                   skid_v;
    logic [ARRAY_DEPTH-1:0] skid_mask;
    logic [DATAW-1:0]       skid_data [ARRAY_DEPTH-1:0];

    // Ready depends only on the registered skid flag (plus flush/reset)
    assign in_ready = !reset && !flush && !skid_v;
    assign accept   = in_valid && in_ready;

    // The skid entry, when present, has priority into stage 0 over new input
    always_comb begin
        stage0_load = !flush && load_ok[0] && (skid_v || accept);
        src_mask    = skid_v ? skid_mask : in_mask;
        for (int l = 0; l < ARRAY_DEPTH; l++) begin
            src_data[l] = skid_v ? skid_data[l] : in_masked[l];
        end
    end

    // Skid register: catches a word accepted while stage 0 cannot take it
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_v    <= 1'b0;
            skid_mask <= '0;
            for (int l = 0; l < ARRAY_DEPTH; l++) begin
                skid_data[l] <= '0;
            end
        end else if (flush) begin
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (load_ok[0]) begin
                skid_v <= 1'b0;
            end
        end else if (accept && !load_ok[0]) begin
            skid_v    <= 1'b1;
            skid_mask <= in_mask;
            for (int l = 0; l < ARRAY_DEPTH; l++) begin
                skid_data[l] <= in_masked[l];
            end
        end
    end
`else
    // Without the skid, ready follows stage 0's ability to load this cycle
    assign in_ready = !reset && !flush && load_ok[0];
    assign accept   = in_valid && in_ready;

    // Stage 0 is fed straight from the (masked) input
    always_comb begin
        stage0_load = accept;
        src_mask    = in_mask;
        for (int l = 0; l < ARRAY_DEPTH; l++) begin
            src_data[l] = in_masked[l];
        end
    end
`endif

    // Pipeline stages and occupancy; flush clears valids only, data registers hold
    always_ff @(posedge clk) begin
        if (reset) begin
            v     <= '0;
            occ_q <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                mask_q[s] <= '0;
                for (int l = 0; l < ARRAY_DEPTH; l++) begin
                    data_q[s][l] <= '0;
                end
            end
        end else if (flush) begin
            v     <= '0;
            occ_q <= '0;
        end else begin
            if (stage0_load) begin
                v[0]      <= 1'b1;
                mask_q[0] <= src_mask;
                for (int l = 0; l < ARRAY_DEPTH; l++) begin
                    data_q[0][l] <= src_data[l];
                end
            end else if (adv[0]) begin
                v[0] <= 1'b0;
            end
            for (int s = 1; s < NUM_STAGES; s++) begin
                if (adv[s-1]) begin
                    v[s]      <= 1'b1;
                    mask_q[s] <= mask_q[s-1];
                    for (int l = 0; l < ARRAY_DEPTH; l++) begin
                        data_q[s][l] <= data_q[s-1][l];
                    end
                end else if (adv[s]) begin
                    v[s] <= 1'b0;
                end
            end
            occ_q <= occ_q + CNTW'(accept) - CNTW'(out_fire);
        end
    end

    // Last stage drives the output ports
    always_comb begin
        out_valid = v[LAST];
        out_mask  = mask_q[LAST];
        for (int l = 0; l < ARRAY_DEPTH; l++) begin
            out_data[l] = data_q[LAST][l];
        end
    end

    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_register_2d.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_pipe_register_2d
//  Description : Scoreboard bench for elastic_pipe_register_2d. Accepted words
//                are pushed into a FIFO model; a monitor pops and compares on
//                every output handshake and tracks occupancy as queue size.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe_register_2d;

    localparam int NS   = 2;
    localparam int DW   = 4;
    localparam int AD   = 4;
    localparam int CW   = $clog2(NS + 2);
`ifdef ELASTIC_PIPE_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    localparam int CAP  = NS + SKID;

    typedef struct {
        logic [DW*AD-1:0] data;
        logic [AD-1:0]    mask;
    } word_t;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data  [AD-1:0];
    logic [DW-1:0] out_data [AD-1:0];
    logic [AD-1:0] in_mask, out_mask;
    logic [CW-1:0] occupancy;

    int    tests  = 0;
    int    fails  = 0;
    bit    mon_en = 1'b0;
    word_t q[$];

    elastic_pipe_register_2d #(
        .DATAW(DW), .ARRAY_DEPTH(AD), .NUM_STAGES(NS)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW*AD-1:0] pack(input logic [DW-1:0] d [AD-1:0]);
        logic [DW*AD-1:0] r;
        for (int l = 0; l < AD; l++) r[l*DW +: DW] = d[l];
        return r;
    endfunction

    task automatic set_word(input logic [DW*AD-1:0] d, input logic [AD-1:0] m);
        for (int l = 0; l < AD; l++) in_data[l] = d[l*DW +: DW];
        in_mask = m;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty;
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while (occupancy != 0 && n < 50) begin
            tick;
            n++;
        end
        chk("drain_to_empty", occupancy, 0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        word_t e;
        logic [DW*AD-1:0] exp_d;
        if (mon_en) begin
            chk("occupancy", occupancy, q.size());
            if (reset) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got data %0h with no word expected", pack(out_data));
                    end else begin
                        e = q.pop_front();
                        chk("out_data", pack(out_data), e.data);
                        chk("out_mask", out_mask, e.mask);
                    end
                end else if (q.size() == 0) begin
                    chk("out_valid_idle", out_valid, 0);
                end
                if (flush) begin
                    chk("ready_in_flush", in_ready, 0);
                    q.delete();
                end else if (in_valid && in_ready) begin
                    for (int l = 0; l < AD; l++)
                        exp_d[l*DW +: DW] = in_mask[l] ? in_data[l] : '0;
                    e.data = exp_d;
                    e.mask = in_mask;
                    q.push_back(e);
                end
            end
        end
    end

    initial begin
        int lat, n;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_word('0, '0);
        @(posedge clk);
        #1 mon_en = 1'b1;
        tick;
        chk("ready_in_reset", in_ready, 0);
        tick;
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_data", pack(out_data), 0);

        // Latency of a single word with no stall
        out_ready = 1'b1;
        set_word(16'h1234, 4'hF);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        chk("latency", lat, NS - 1);
        wait_empty();

        // Stream 1..8 back to back at full throughput
        for (int i = 1; i <= 8; i++) begin
            set_word({4{i[3:0]}}, 4'hF);
            in_valid = 1'b1;
            chk("stream_ready", in_ready, 1);
            tick;
        end
        wait_empty();

        // Fill under backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        while (in_ready && n < 20) begin
            set_word(16'($urandom), 4'hF);
            tick;
            n++;
        end
        chk("fill_accepts", n, CAP);
        chk("fill_occupancy", occupancy, CAP);
        chk("full_ready", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ready_on_release", in_ready, 1 - SKID);
        tick;
        wait_empty();

        // Bubble collapse: A, gap, B under stall
        out_ready = 1'b0;
        set_word(16'hAAAA, 4'hF); in_valid = 1'b1; tick;
        in_valid = 1'b0; tick;
        set_word(16'hBBBB, 4'hF); in_valid = 1'b1; tick;
        in_valid = 1'b0;
        repeat (NS) tick;
        chk("collapse_occupancy", occupancy, 2);
        chk("collapse_out_valid", out_valid, 1);
        chk("collapse_ready", in_ready, ((NS > 2) || (SKID != 0)) ? 1 : 0);
        wait_empty();

        // Lane masking
        set_word(16'hAAAA, 4'b0101);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick;
            n++;
        end
        chk("mask_lane0", out_data[0], 4'hA);
        chk("mask_lane1", out_data[1], 0);
        chk("mask_lane2", out_data[2], 4'hA);
        chk("mask_lane3", out_data[3], 0);
        chk("mask_out", out_mask, 4'b0101);
        wait_empty();

        // Flush while full with an input offered
        out_ready = 1'b0;
        set_word(16'h1111, 4'hF); in_valid = 1'b1; tick;
        set_word(16'h2222, 4'hF); tick;
        set_word(16'h3333, 4'hF); flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_occupancy", occupancy, 0);
        set_word(16'h4444, 4'hF); in_valid = 1'b1; out_ready = 1'b1; tick;
        wait_empty();

        // Flush coinciding with an output handshake
        out_ready = 1'b0;
        set_word(16'h5555, 4'h3); in_valid = 1'b1; tick;
        set_word(16'h6666, 4'hC); tick;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; tick;
        flush = 1'b0;
        chk("flush_hs_occupancy", occupancy, 0);
        wait_empty();

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            set_word(16'($urandom), 4'($urandom));
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 399) == 0);
            tick;
        end
        flush = 1'b0;
        reset = 1'b0;
        wait_empty();
        tick;
        chk("final_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
